dac_update_scheduler: RTL
=========================

DAC_UPDATE_SCHEDULER -- requirements
Module: dac_update_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FP_WIDTH, 64, fixed-point word width, 16.48 format.
- DAC_WIDTH, 14, DAC code width.
- N_CH, 4, number of DAC channels sharing one converter datapath.
- CH_W, 2, channel select width (clog2 N_CH).
- CONV_LATENCY, 1, converter latency in cycles from operands to valid CONV_CODE; legal range 1..15.
- RESET_CODE, 14'h2000, per-channel DAC code after reset.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1, sole clock, rising edge.
- RSTN, in, 1, reset, synchronous, active-low.
- REQ, in, N_CH, per-channel update request, level, held until ACK.
- VOLT_IN, in, N_CH*FP_WIDTH, target voltage; channel i at bits [i*FP_WIDTH +: FP_WIDTH].
- ACK, out, N_CH, one-cycle grant pulse per channel.
- CAL_WE, in, 1, calibration write strobe.
- CAL_SEL, in, CH_W, calibration target channel.
- CAL_GAIN, in, FP_WIDTH, gain write data.
- CAL_OFFSET, in, FP_WIDTH, offset write data.
- CONV_VOLTAGE, out, FP_WIDTH, converter voltage operand.
- CONV_GAIN, out, FP_WIDTH, converter gain operand.
- CONV_OFFSET, out, FP_WIDTH, converter offset operand.
- CONV_CODE, in, DAC_WIDTH, converter result.
- DAC_CODE, out, N_CH*DAC_WIDTH, held per-channel codes; channel i at [i*DAC_WIDTH +: DAC_WIDTH].
- DAC_UPDATE, out, N_CH, one-cycle pulse when a channel's DAC_CODE changes.
- BUSY, out, 1, high whenever state is not IDLE.

Function
REQ-003 The block SHALL implement states IDLE and WAIT; BUSY = (state == WAIT) registered-equivalent, no combinational path from REQ.
REQ-004 In IDLE with any REQ bit high, the block SHALL grant one channel by round-robin: search from (LAST_GRANT+1) mod N_CH upward with wrap; first set bit wins.
REQ-005 On the grant edge the block SHALL: load CONV_VOLTAGE from the channel's VOLT_IN slice, CONV_GAIN/CONV_OFFSET from that channel's calibration registers, update LAST_GRANT, load the latency counter, enter WAIT, and assert ACK[ch] for exactly the following cycle.
REQ-006 Grant decided in cycle T SHALL give ACK[ch]=1 in T+1, WAIT in T+1..T+CONV_LATENCY, CONV_CODE sampled at end of T+CONV_LATENCY, DAC_CODE slot and DAC_UPDATE[ch]=1 in T+CONV_LATENCY+1, state IDLE in T+CONV_LATENCY+1.
REQ-007 A new grant SHALL be possible in the same cycle DAC_UPDATE pulses; sustained throughput is one update per CONV_LATENCY+1 cycles.
REQ-008 CONV_* operands SHALL remain stable throughout WAIT and hold their last value in IDLE.
REQ-009 REQ changes during WAIT SHALL be ignored; a REQ still high at the next IDLE cycle SHALL be treated as a new request.
REQ-010 At most one ACK bit and at most one DAC_UPDATE bit SHALL be high in any cycle; non-granted channels' DAC_CODE slots SHALL not change.
REQ-011 CAL_WE=1 SHALL write CAL_GAIN/CAL_OFFSET into channel CAL_SEL registers at the edge, in any state; CAL_SEL >= N_CH SHALL be ignored.
REQ-012 A calibration write coincident with or after a grant SHALL not alter in-flight operands (snapshot rule); it SHALL apply from that channel's next grant.
REQ-013 A calibration write and grant to the same channel on the same edge SHALL use the pre-write values.
REQ-014 The block SHALL perform no arithmetic on codes; CONV_CODE SHALL be stored unmodified.

Reset
REQ-015 RSTN=0 at an edge SHALL force: state IDLE, LAST_GRANT = N_CH-1, ACK=0, DAC_UPDATE=0, BUSY=0, all DAC_CODE slots = RESET_CODE, CONV_* = 0, gains = 64'h0001_0000_0000_0000 (1.0), offsets = 0.
REQ-016 Reset during WAIT SHALL abandon the conversion with no DAC_UPDATE pulse and no DAC_CODE change beyond REQ-015.
REQ-017 With RSTN=0, CAL_WE and REQ SHALL be ignored.

Verification
REQ-018 Post-reset: read all outputs -> DAC_CODE all 14'h2000, ACK/DAC_UPDATE/BUSY 0.
REQ-019 Single: REQ[2]=1, VOLT_IN[2]=64'h0001_0000_0000_0000, CONV_LATENCY=3, converter stub returns 14'h1234 -> ACK[2] at T+1, DAC_UPDATE[2] and DAC_CODE[2]=14'h1234 at T+4.
REQ-020 Fairness: REQ=4'b1111 held (dropping each bit after its ACK) -> grant order 0,1,2,3; then REQ=4'b1001 held permanently -> order 0,3,0,3.
REQ-021 Snapshot: grant ch1, during WAIT write CAL_SEL=1 gain 64'h0002_0000_0000_0000 -> CONV_GAIN stays 1.0 this update, equals 2.0 on ch1's next grant; CAL_SEL=3'd? out-of-range (N_CH=3 build) write ignored.
REQ-022 Reset mid-WAIT: assert RSTN=0 for one cycle at T+2 with CONV_LATENCY=3 -> no DAC_UPDATE, DAC_CODE all RESET_CODE, next grant goes to channel 0.

Source files
------------

// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
//
// Time-shares one external DAC code converter between N_CH channels.
// Channels raise REQ and hold it until ACK. A round-robin arbiter picks one
// channel while the block is idle. The converter operands (voltage, gain,
// offset) are latched on the grant edge and held stable for the whole
// conversion. After CONV_LATENCY cycles the returned CONV_CODE is stored
// unmodified in that channel's DAC_CODE slot, and DAC_UPDATE pulses.
//
// Ports
//   CLK, RSTN            clock (rising edge); synchronous active-low reset
//   REQ / ACK            per-channel level request / one-cycle grant pulse
//   VOLT_IN              packed per-channel target voltages (16.48)
//   CAL_WE/SEL/GAIN/OFFSET  per-channel calibration register write port
//   CONV_VOLTAGE/GAIN/OFFSET  operands presented to the converter
//   CONV_CODE            converter result
//   DAC_CODE             packed held per-channel codes
//   DAC_UPDATE           one-cycle pulse on the channel whose code was written
//   BUSY                 high while a conversion is in flight
module dac_update_scheduler #(
  parameter int                   FP_WIDTH     = 64,
  parameter int                   DAC_WIDTH    = 14,
  parameter int                   N_CH         = 4,
  parameter int                   CH_W         = 2,
  parameter int                   CONV_LATENCY = 1,
  parameter logic [DAC_WIDTH-1:0] RESET_CODE   = 14'h2000
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [N_CH-1:0]           REQ,
  input  logic [N_CH*FP_WIDTH-1:0]  VOLT_IN,
  output logic [N_CH-1:0]           ACK,
  input  logic                      CAL_WE,
  input  logic [CH_W-1:0]           CAL_SEL,
  input  logic [FP_WIDTH-1:0]       CAL_GAIN,
  input  logic [FP_WIDTH-1:0]       CAL_OFFSET,
  output logic [FP_WIDTH-1:0]       CONV_VOLTAGE,
  output logic [FP_WIDTH-1:0]       CONV_GAIN,
  output logic [FP_WIDTH-1:0]       CONV_OFFSET,
  input  logic [DAC_WIDTH-1:0]      CONV_CODE,
  output logic [N_CH*DAC_WIDTH-1:0] DAC_CODE,
  output logic [N_CH-1:0]           DAC_UPDATE,
  output logic                      BUSY
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [FP_WIDTH-1:0] GAIN_ONE = FP_WIDTH'(64'h0001_0000_0000_0000);
  // Counter is loaded with latency-1 so that it reads zero in the last WAIT cycle.
  localparam logic [3:0]          LAT_M1   = 4'(CONV_LATENCY - 1);
  localparam logic [N_CH-1:0]     CH_ONE   = N_CH'(1'b1);
  localparam logic [CH_W:0]       CH_LIMIT = (CH_W+1)'(N_CH);

  state_t                state_q, state_d;
  logic [CH_W-1:0]       last_grant_q;
  logic [3:0]            cnt_q;
  logic [N_CH-1:0]       ack_q;
  logic [N_CH-1:0]       dac_update_q;
  logic [FP_WIDTH-1:0]   conv_volt_q, conv_gain_q, conv_off_q;
  logic [FP_WIDTH-1:0]   gain_q [N_CH];
  logic [FP_WIDTH-1:0]   off_q  [N_CH];
  logic [DAC_WIDTH-1:0]  code_q [N_CH];
  logic [FP_WIDTH-1:0]   volt_s [N_CH];

  logic                  grant_s;
  logic                  finish_s;
  logic [CH_W-1:0]       pick_s;
  logic                  cal_hit_s;

  // Round-robin pick: scan from last+N_CH down to last+1 (mod N_CH) so that
  // the final hit, the one closest after the last grant, wins.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [CH_W-1:0] last);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] cand;
    int              idx;
    pick = last;
    for (int i = N_CH; i >= 1; i--) begin
      idx  = (int'(last) + i) % N_CH;
      cand = CH_W'(idx);
      if (req[cand]) begin
        pick = cand;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      assign volt_s[g]                          = VOLT_IN[g*FP_WIDTH +: FP_WIDTH];
      assign DAC_CODE[g*DAC_WIDTH +: DAC_WIDTH] = code_q[g];
    end
  endgenerate

  // Out-of-range calibration targets are dropped.
  assign cal_hit_s = CAL_WE && ({1'b0, CAL_SEL} < CH_LIMIT);
  assign pick_s    = rr_pick(REQ, last_grant_q);

  // Next-state logic: grant from IDLE on any request, return when counter expires.
  always_comb begin
    state_d  = state_q;
    grant_s  = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          grant_s = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          finish_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand snapshot, latency counter, result capture, calibration.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      last_grant_q <= CH_W'(N_CH - 1);
      cnt_q        <= 4'd0;
      ack_q        <= '0;
      dac_update_q <= '0;
      conv_volt_q  <= '0;
      conv_gain_q  <= '0;
      conv_off_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        gain_q[i] <= GAIN_ONE;
        off_q[i]  <= '0;
        code_q[i] <= RESET_CODE;
      end
    end else begin
      ack_q        <= '0;
      dac_update_q <= '0;
      if (grant_s) begin
        // Nonblocking reads here see calibration values from before any
        // same-edge write, so the snapshot is always the pre-write set.
        conv_volt_q  <= volt_s[pick_s];
        conv_gain_q  <= gain_q[pick_s];
        conv_off_q   <= off_q[pick_s];
        last_grant_q <= pick_s;
        cnt_q        <= LAT_M1;
        ack_q        <= CH_ONE << pick_s;
      end else if ((state_q == ST_WAIT) && !finish_s) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (finish_s) begin
        code_q[last_grant_q] <= CONV_CODE;
        dac_update_q         <= CH_ONE << last_grant_q;
      end
      if (cal_hit_s) begin
        gain_q[CAL_SEL] <= CAL_GAIN;
        off_q[CAL_SEL]  <= CAL_OFFSET;
      end
    end
  end

  assign ACK          = ack_q;
  assign DAC_UPDATE   = dac_update_q;
  assign BUSY         = (state_q == ST_WAIT);
  assign CONV_VOLTAGE = conv_volt_q;
  assign CONV_GAIN    = conv_gain_q;
  assign CONV_OFFSET  = conv_off_q;

endmodule
